// File: rtl/sseg_scan.sv
// Four-digit multiplexed seven-segment scanner with blank gaps between digits,
// double-buffered display data and optional leading-zero blanking.
module sseg_scan #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  digit,
  output logic        dp_out,
  output logic [3:0]  an,
  output logic        frame_start
);

  typedef enum logic {BLANK, SHOW} state_t;

  // 20 bits holds the largest legal phase length minus one for either phase
  localparam int CW = 20;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;

  logic [15:0]   shadow_val;
  logic [3:0]    shadow_dp;
  logic          shadow_blz;
  logic          pending;

  logic [15:0]   active_val;
  logic [3:0]    active_dp;
  logic          active_blz;

  logic [1:0]    next_idx;
  logic          boundary;
  logic [15:0]   nxt_val;
  logic [3:0]    nxt_dp;
  logic          nxt_blz;

  // A position is dark when blanking is on and it and every digit left of it are zero
  function automatic logic pos_blanked(input logic [15:0] v, input logic blz,
                                       input logic [1:0] p);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k >= int'(p) && v[4*k +: 4] != 4'h0) upper_zero = 1'b0;
    end
    return blz && (p != 2'd0) && upper_zero;
  endfunction

  // At the frame boundary the idx-0 digit must come from the freshly transferred data
  always_comb begin
    next_idx = idx + 2'd1;
    boundary = (state == SHOW) && (cnt == SHOW_LAST) && (idx == 2'd3);
    nxt_val  = active_val;
    nxt_dp   = active_dp;
    nxt_blz  = active_blz;
    if (boundary && pending) begin
      nxt_val = shadow_val;
      nxt_dp  = shadow_dp;
      nxt_blz = shadow_blz;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BLANK;
      cnt         <= '0;
      idx         <= 2'd0;
      an          <= 4'hF;
      digit       <= 4'h0;
      dp_out      <= 1'b0;
      frame_start <= 1'b0;
      shadow_val  <= 16'h0;
      shadow_dp   <= 4'h0;
      shadow_blz  <= 1'b0;
      pending     <= 1'b0;
      active_val  <= 16'h0;
      active_dp   <= 4'h0;
      active_blz  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
        shadow_blz <= blank_lz;
        pending    <= 1'b1;
      end
      case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state <= SHOW;
            cnt   <= '0;
            an    <= pos_blanked(active_val, active_blz, idx) ? 4'hF
                                                              : ~(4'b0001 << idx);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state  <= BLANK;
            cnt    <= '0;
            idx    <= next_idx;
            an     <= 4'hF;
            digit  <= nxt_val[{next_idx, 2'b00} +: 4];
            dp_out <= nxt_dp[next_idx] & ~pos_blanked(nxt_val, nxt_blz, next_idx);
            if (boundary) begin
              frame_start <= 1'b1;
              // A load on this same cycle keeps pending set for the following frame
              if (pending) begin
                active_val <= shadow_val;
                active_dp  <= shadow_dp;
                active_blz <= shadow_blz;
                if (!load) pending <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

endmodule
